// File: rtl/mac_window_accumulator.sv
// Sums each group of WINDOW valid results and queues the sums in a 2-entry FIFO.
// Latency: a window sum reaches out_valid one cycle after the edge that takes the window's last sample.
// Never stalls upstream; a sum that finds the FIFO full with no pop is dropped and drop_err is set.
package params;
  localparam int DATA_OUT_WIDTH = 16;
endpackage

module mac_window_accumulator #(
  parameter int DATA_OUT_WIDTH = params::DATA_OUT_WIDTH,
  parameter int ACC_WIDTH      = 18,
  parameter int WINDOW         = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_valid,
  input  logic [DATA_OUT_WIDTH-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_data,
  output logic                         out_sat,
  output logic [$clog2(WINDOW)-1:0]    win_cnt,
  output logic                         drop_err
);

  localparam int                CNT_W   = $clog2(WINDOW);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  // Window accumulator state
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_sat;
  logic [CNT_W-1:0]     r_win_cnt;

  // FIFO: the head entry doubles as the registered output, the tail holds the second entry
  logic [ACC_WIDTH-1:0] r_head_dat;
  logic                 r_head_sat;
  logic [ACC_WIDTH-1:0] r_tail_dat;
  logic                 r_tail_sat;
  logic [1:0]           r_count;
  logic                 r_drop_err;

  logic [ACC_WIDTH:0]   w_in_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_sum_sat;
  logic                 w_sat_new;
  logic                 w_close;
  logic                 w_pop;
  logic                 w_full;

  assign w_in_ext  = {{(ACC_WIDTH + 1 - DATA_OUT_WIDTH){1'b0}}, in_data};
  assign w_sum     = {1'b0, r_acc} + w_in_ext;
  // A carry out of the accumulator width means the sum exceeded the representable maximum
  assign w_sum_sat = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
  assign w_sat_new = r_sat | w_sum[ACC_WIDTH];
  assign w_close   = in_valid && (r_win_cnt == LAST);
  assign w_pop     = out_valid && out_ready;
  assign w_full    = (r_count == 2'd2);

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head_dat;
  assign out_sat   = r_head_sat;
  assign win_cnt   = r_win_cnt;
  assign drop_err  = r_drop_err;

  // Accumulate valid samples; closing a window restarts the sum from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_win_cnt <= '0;
    end else if (clr) begin
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_win_cnt <= '0;
    end else if (w_close) begin
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_win_cnt <= '0;
    end else if (in_valid) begin
      r_acc     <= w_sum_sat;
      r_sat     <= w_sat_new;
      r_win_cnt <= r_win_cnt + CNT_ONE;
    end
  end

  // FIFO update; a pop frees a slot before the push is considered, so full+pop+push keeps all data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_dat <= '0;
      r_head_sat <= 1'b0;
      r_tail_dat <= '0;
      r_tail_sat <= 1'b0;
      r_count    <= 2'd0;
      r_drop_err <= 1'b0;
    end else if (clr) begin
      r_head_dat <= '0;
      r_head_sat <= 1'b0;
      r_tail_dat <= '0;
      r_tail_sat <= 1'b0;
      r_count    <= 2'd0;
      r_drop_err <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_close) begin
            r_head_dat <= w_sum_sat;
            r_head_sat <= w_sat_new;
            r_count    <= 2'd1;
          end
        end
        2'd1: begin
          if (w_close && w_pop) begin
            r_head_dat <= w_sum_sat;
            r_head_sat <= w_sat_new;
          end else if (w_close) begin
            r_tail_dat <= w_sum_sat;
            r_tail_sat <= w_sat_new;
            r_count    <= 2'd2;
          end else if (w_pop) begin
            r_count    <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head_dat <= r_tail_dat;
            r_head_sat <= r_tail_sat;
            if (w_close) begin
              r_tail_dat <= w_sum_sat;
              r_tail_sat <= w_sat_new;
            end else begin
              r_count    <= 2'd1;
            end
          end
        end
      endcase
      if (w_close && w_full && !w_pop) begin
        r_drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mac_window_accumulator.md
Name: mac_window_accumulator

Overview:
- Downstream consumer of the multiply-add pipeline stage.
- Takes the stage's DATA_OUT result stream, qualified by a valid strobe, and sums each consecutive group of WINDOW results.
- Each window sum is pushed into a 2-entry output FIFO read through a valid/ready handshake.
- The upstream pipeline cannot be stalled, so this block never back-pressures it. Overflowing results are dropped and flagged.

Parameters:
- DATA_OUT_WIDTH, default params::DATA_OUT_WIDTH (16): width of the incoming result.
- ACC_WIDTH, default 18: accumulator and output width. Must be >= DATA_OUT_WIDTH.
- WINDOW, default 4: results per window. Range 2..256.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: flush window, FIFO and error flag.
- in_valid  in  1  in_data carries a valid pipeline result this cycle.
- in_data  in  DATA_OUT_WIDTH  result from the multiply-add stage, unsigned.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head this cycle.
- out_data  out  ACC_WIDTH  window sum at FIFO head.
- out_sat  out  1  head sum was saturated.
- win_cnt  out  $clog2(WINDOW)  samples accepted in the current window.
- drop_err  out  1  sticky: at least one window sum was lost.

Behaviour:
- Reset (rst_n low, asynchronous): acc, win_cnt, FIFO pointers/count, out_valid, out_data, out_sat, drop_err all 0.
- Accumulation:
  - All arithmetic is unsigned. in_data is zero-extended to ACC_WIDTH+1 before adding.
  - If acc+in_data > 2^ACC_WIDTH-1, acc holds 2^ACC_WIDTH-1 and a per-window sat bit is set. The sat bit stays set until the window closes.
- Window close: on in_valid with win_cnt==WINDOW-1, the same edge does all of the following:
  - pushes {sat, saturated acc+in_data} to the FIFO;
  - sets acc to 0, win_cnt to 0 and sat to 0.
- Otherwise, on in_valid: acc updates and win_cnt increments.
- Latency: with the FIFO empty, out_valid rises in the cycle after the edge that accepts the last sample of a window.
- FIFO: 2 entries.
  - out_data and out_sat are registered copies of the head entry. They hold steady while out_valid=1 and out_ready=0.
  - Pop happens when out_valid and out_ready are both high. The next entry, if any, is presented on the following cycle.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full: the pop frees a slot for the push.
  - Full with no pop at a window close: the new sum is discarded and drop_err is set to 1. FIFO contents are unchanged.
  - When out_valid=0, out_data and out_sat keep their last value, 0 after reset. They are don't-care for checking.
- drop_err is cleared only by clr or reset.
- clr (synchronous):
  - Next edge: acc, win_cnt, sat, FIFO and drop_err go to 0.
  - clr has priority: an in_valid sample in the same cycle is discarded, and any pop in the same cycle has no further effect.
- Reset asserted mid-window or with the FIFO non-empty: all state is lost immediately. No partial sum is ever output.
- in_data is ignored when in_valid=0. acc and win_cnt hold.
- Gaps in in_valid are allowed anywhere. A window spans any number of cycles.

Test Plan:
- Basic window: WINDOW=4, ACC_WIDTH=18, in_valid held high with in_data 1,2,3,4, out_ready=1 -> one cycle after the 4th sample, out_valid=1 for one cycle with out_data=10 and out_sat=0; win_cnt sequence is 1,2,3,0.
- Saturation: ACC_WIDTH=17, four samples of 0xFFFF -> out_data=131071, out_sat=1. The next window 1,1,1,1 -> out_data=4, out_sat=0.
- Backpressure and drop: out_ready=0, three windows of 5,5,5,5 back-to-back ->
  - FIFO holds 20,20; out_data=20 stays stable;
  - drop_err=1 after the third window closes.
  - Then raise out_ready -> exactly two results of 20 are popped, and drop_err stays 1.
- Full with simultaneous pop: FIFO full, the 4th sample arrives in the same cycle as out_ready=1 -> no drop, drop_err stays 0, and the three sums emerge in order.
- clr mid-window: after samples 7,7, pulse clr together with in_valid and in_data=7, then send 1,1,1,1 -> only out_data=4 appears; drop_err=0 and win_cnt=0 after clr.
- Async reset: assert rst_n=0 between clock edges with win_cnt=2 and one FIFO entry -> out_valid, win_cnt and drop_err go to 0 immediately, without waiting for a clock edge; after release, a fresh window 2,2,2,2 gives 8.
